// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-cycle rotate/shift unit that sits beside the ALU.
// It handles ROR, ROL, SHR, SHL and SHRA on a WIDTH-bit operand. Each clock
// resolves BITS_PER_CYCLE bits of the amount, so a log shifter is spread over
// NCYC cycles. The control unit drives it with a start/busy/done handshake.
// Optional build macro: SHIFT_SATURATE_EN. When it is defined, a shift by
// Amount >= WIDTH saturates. When it is not defined, shifts use Amount mod WIDTH.
module shift_rotate_unit #(
    parameter int WIDTH          = 32,
    parameter int AMT_W          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [AMT_W-1:0] Amount,
    output logic [WIDTH-1:0] Rz,
    output logic             busy,
    output logic             done
);
    localparam int SHAMT_W  = $clog2(WIDTH);
    localparam int NCYC     = (SHAMT_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int AMT_PAD  = NCYC * BITS_PER_CYCLE;
    localparam int STEP_W   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NCYC - 1);
    localparam logic [AMT_W-1:0]  AMT_MASK  = AMT_W'((64'd1 << SHAMT_W) - 64'd1);

    localparam logic [2:0] OP_ROR  = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHRA = 3'b100;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_PAD-1:0] amt_q, amt_d;
    logic [WIDTH-1:0]   rz_q, rz_d;
    logic               done_q, done_d;

    logic [AMT_PAD-1:0] amt_eff;
    logic [AMT_PAD-1:0] chunk;
    logic [WIDTH-1:0]   step_res;
    logic               sat;

    // One sub-shift by s, where s < WIDTH. Ops 101-111 pass the operand through.
    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input int s);
        logic [2*WIDTH-1:0] dbl;
        dbl = '0;
        case (o)
            OP_ROR: begin
                dbl = {x, x} >> s;
                return dbl[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl = {x, x} << s;
                return dbl[2*WIDTH-1:WIDTH];
            end
            OP_SHR:  return x >> s;
            OP_SHL:  return x << s;
            OP_SHRA: return $unsigned($signed(x) >>> s);
            default: return x;
        endcase
    endfunction

    // Control state register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: IDLE waits for start, RUN lasts exactly NCYC steps
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (step_q == LAST_STEP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs derived from state and registered result
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        Rz   = rz_q;
    end

    // Saturation decision on the raw amount, taken only at the start edge
    always_comb begin
        amt_eff = AMT_PAD'(Amount & AMT_MASK);
`ifdef SHIFT_SATURATE_EN
        sat = (op == OP_SHR || op == OP_SHL || op == OP_SHRA) &&
              (|(Amount >> SHAMT_W));
`else
        sat = 1'b0;
`endif
    end

    // One step: apply this step's amount bits as sub-shifts of 2^bit_index
    always_comb begin
        step_res = work_q;
        chunk    = amt_q >> (int'(step_q) * BITS_PER_CYCLE);
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (chunk[i] && (int'(step_q) * BITS_PER_CYCLE + i) < SHAMT_W)
                step_res = apply_op(op_q, step_res,
                                    1 << (int'(step_q) * BITS_PER_CYCLE + i));
        end
    end

    // Datapath next-state: latch operands on start, iterate, publish on the last step
    always_comb begin
        step_d = step_q;
        op_d   = op_q;
        work_d = work_q;
        amt_d  = amt_q;
        rz_d   = rz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    step_d = '0;
                    if (sat) begin
                        // A saturated shift is already complete: load the
                        // final value and a zero amount, so latency does not change.
                        work_d = (op == OP_SHRA) ? {WIDTH{Ra[WIDTH-1]}} : '0;
                        amt_d  = '0;
                    end else begin
                        work_d = Ra;
                        amt_d  = amt_eff;
                    end
                end
            end
            RUN: begin
                work_d = step_res;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    rz_d   = step_res;
                    done_d = 1'b1;
                    step_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; a reset aborts any operation in flight
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            step_q <= '0;
            op_q   <= '0;
            work_q <= '0;
            amt_q  <= '0;
            rz_q   <= '0;
            done_q <= 1'b0;
        end else begin
            step_q <= step_d;
            op_q   <= op_d;
            work_q <= work_d;
            amt_q  <= amt_d;
            rz_q   <= rz_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit with the default parameters (32-bit).
module tb_shift_rotate_unit;
    localparam int NCYC = 5;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] Ra = '0;
    logic [31:0] Amount = '0;
    logic [31:0] Rz;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rz;
        int          due;
        string       name;
    } exp_t;
    exp_t q[$];

    shift_rotate_unit dut (
        .clock(clock), .clear_n(clear_n), .start(start), .op(op),
        .Ra(Ra), .Amount(Amount), .Rz(Rz), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model built from single-bit rotate/shift steps
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] amt);
        logic [31:0] r;
        int n;
        bit sat;
        r = a;
        n = int'(amt % 32);
        sat = 1'b0;
`ifdef SHIFT_SATURATE_EN
        sat = (amt >= 32) && (o == 3'd2 || o == 3'd3 || o == 3'd4);
`endif
        case (o)
            3'd0: for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
            3'd1: for (int k = 0; k < n; k++) r = {r[30:0], r[31]};
            3'd2: r = sat ? 32'd0 : a / (32'd1 << n);
            3'd3: r = sat ? 32'd0 : a * (32'd1 << n);
            3'd4: if (sat) r = {32{a[31]}};
                  else for (int k = 0; k < n; k++) r = {r[31], r[31:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    // Monitor: every done must match the oldest outstanding request, on time
    always @(negedge clock) begin
        if (clear_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_rz"}, Rz, e.rz);
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_missing_done"}, 32'd0, 32'd1);
        end
    end

    // Called at a negedge: wait until the unit is idle, then present one request
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] amt,
                         input logic [31:0] exp, input string nm);
        int g = 0;
        while (busy && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
        op = o; Ra = a; Amount = amt; start = 1'b1;
        q.push_back('{exp, cyc + NCYC + 1, nm});
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, amt;

        repeat (3) @(negedge clock);
        chk("reset_rz", Rz, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        clear_n = 1'b1;
        @(negedge clock);

        // Latency and busy window for ROR
        issue(3'd0, 32'h8000_0001, 32'd1, 32'hC000_0000, "ror1");
        for (int k = 0; k < NCYC; k++) begin
            chk("ror1_busy", {31'd0, busy}, 32'd1);
            chk("ror1_done_early", {31'd0, done}, 32'd0);
            @(negedge clock);
        end
        chk("ror1_busy_end", {31'd0, busy}, 32'd0);
        chk("ror1_done_pulse", {31'd0, done}, 32'd1);
        drain();

        // Directed vectors
        issue(3'd1, 32'h1234_5678, 32'd8,  32'h3456_7812, "rol8");
        issue(3'd0, 32'h1234_5678, 32'd36, 32'h8123_4567, "ror36");
        issue(3'd4, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, "shra31");
        issue(3'd2, 32'h8000_0000, 32'd31, 32'h0000_0001, "shr31");
        issue(3'd3, 32'h0000_0001, 32'd0,  32'h0000_0001, "shl0");
`ifdef SHIFT_SATURATE_EN
        issue(3'd2, 32'hF000_0000, 32'd33, 32'h0000_0000, "shr33");
        issue(3'd4, 32'h8000_0000, 32'd64, 32'hFFFF_FFFF, "shra64");
`else
        issue(3'd2, 32'hF000_0000, 32'd33, 32'h7800_0000, "shr33");
        issue(3'd4, 32'h8000_0000, 32'd64, 32'h8000_0000, "shra64");
`endif
        issue(3'd5, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF, "pass");
        drain();

        // A start while busy is ignored
        issue(3'd0, 32'h0000_000F, 32'd4, 32'hF000_0000, "ror_ign");
        @(negedge clock);
        op = 3'd3; Ra = 32'h1111_1111; Amount = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clock);

        // A start in the done cycle is accepted
        issue(3'd1, 32'h0000_00FF, 32'd4, 32'h0000_0FF0, "b2b_a");
        begin
            int g = 0;
            while (!done && g < 20) begin
                @(negedge clock);
                g++;
            end
        end
        chk("b2b_in_done_cycle", {31'd0, done}, 32'd1);
        issue(3'd2, 32'h0000_0F00, 32'd8, 32'h0000_000F, "b2b_b");
        drain();

        // Reset mid-operation
        issue(3'd3, 32'h0000_0003, 32'd5, 32'h0000_0060, "rst_op");
        repeat (2) @(negedge clock);
        clear_n = 1'b0;
        #1;
        chk("midrst_rz", Rz, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        q.delete();
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        repeat (10) @(negedge clock);
        issue(3'd0, 32'h0000_0002, 32'd1, 32'h0000_0001, "after_rst");
        drain();

        // Randomised traffic that includes inputs which change while busy
        for (int n = 0; n < 60; n++) begin
            o   = 3'($urandom_range(0, 7));
            a   = $urandom;
            amt = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(o, a, amt, model(o, a, amt), "rand");
            if ($urandom_range(0, 1) == 1) begin
                op = 3'($urandom_range(0, 7)); Ra = $urandom; Amount = $urandom;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
